// File: rtl/mem_ahb_pkg.sv
// AHB-Lite encodings and helpers for the memory-subsystem slaves.
package mem_ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    SIZE_BYTE   = 3'd0,
    SIZE_HALF   = 3'd1,
    SIZE_WORD   = 3'd2,
    SIZE_DWORD  = 3'd3,
    SIZE_QWORD  = 3'd4,
    SIZE_8WORD  = 3'd5,
    SIZE_16WORD = 3'd6,
    SIZE_32WORD = 3'd7
  } hsize_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_e;

  // Number of byte-address bits that select a lane within one data word.
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/proj_param_pkg.sv
// AHB width limits shared across the project; blocks derive their default port widths from these.
package proj_param_pkg;
  localparam int PROJ_HADDR = 32;
  localparam int PROJ_HDATA = 32;
endpackage

// File: rtl/mem_ahb_byte_en.sv
// Byte-lane strobe decoder: marks the lanes covered by a transfer of 2**size bytes at addr.
module mem_ahb_byte_en
  import mem_ahb_pkg::*;
#(
  parameter int DATA = 32
) (
  input  logic [2:0]                   size,
  input  logic [lane_bits(DATA)-1:0]   addr,
  output logic [DATA/8-1:0]            strobe
);
  localparam int NB = DATA / 8;
  localparam int LB = lane_bits(DATA);

  logic [LB-1:0] low_mask;
  logic [LB-1:0] hi_mask;

  // Sizes at or above the word size saturate to all-ones, enabling every lane.
  assign low_mask = LB'((32'd1 << size) - 32'd1);
  assign hi_mask  = ~low_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [LB-1:0] lane_idx;
      assign lane_idx    = LB'(gi);
      assign strobe[gi]  = ((lane_idx ^ addr) & hi_mask) == '0;
    end
  endgenerate

endmodule

// File: rtl/mem_ahb_sram.sv
// AHB-Lite on-chip SRAM slave with programmable wait states, byte-lane writes and two-cycle ERROR.
module mem_ahb_sram
  import mem_ahb_pkg::*;
#(
  parameter int ADDR        = proj_param_pkg::PROJ_HADDR,
  parameter int DATA        = proj_param_pkg::PROJ_HDATA,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int INIT_ZERO   = 0
) (
  input  logic            hclk,
  input  logic            hreset,
  input  logic            hsel,
  input  logic [ADDR-1:0] haddr,
  input  logic [1:0]      htrans,
  input  logic            hwrite,
  input  logic [2:0]      hsize,
  input  logic [2:0]      hburst,
  input  logic            hready,
  input  logic [DATA-1:0] hwdata,
  output logic [DATA-1:0] hrdata,
  output logic            hreadyout,
  output logic            hresp
);
  localparam int NB = DATA / 8;
  localparam int LB = lane_bits(DATA);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA-1:0] mem [DEPTH];

  state_e          state_q;
  hresp_e          hresp_q;
  logic            hreadyout_q;
  logic [3:0]      wcnt_q;
  logic            dp_active_q;
  logic            err_q;
  logic            write_q;
  logic [ADDR-1:0] addr_q;
  logic [2:0]      size_q;

  logic            accept;
  logic            acc_err;
  logic            range_err;
  logic            size_err;
  logic            align_err;
  logic [NB-1:0]   byte_en;
  logic [AW-1:0]   word_idx;
  logic            wr_commit;
  logic            unused_bits;

  assign accept = hsel && hready && (htrans == TRANS_NONSEQ || htrans == TRANS_SEQ);

  assign range_err = (haddr >> LB) >= ADDR'(DEPTH);
  assign size_err  = hsize > 3'(LB);
  assign align_err = (haddr & ((ADDR'(1) << hsize) - ADDR'(1))) != '0;
  assign acc_err   = range_err || size_err || align_err;

  // hreadyout_q is high only in IDLE and ERR2, so acceptance is evaluated there alone.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
      wcnt_q      <= '0;
      dp_active_q <= 1'b0;
      err_q       <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
    end else begin
      case (state_q)
        WAIT: begin
          if (wcnt_q == '0) begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        ERR1: begin
          state_q     <= ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= RESP_ERROR;
        end
        default: begin
          if (accept) begin
            addr_q      <= haddr;
            write_q     <= hwrite;
            size_q      <= hsize;
            err_q       <= acc_err;
            dp_active_q <= 1'b1;
            if (acc_err) begin
              state_q     <= ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= RESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state_q     <= WAIT;
              wcnt_q      <= 4'(WAIT_STATES - 1);
              hreadyout_q <= 1'b0;
              hresp_q     <= RESP_OKAY;
            end else begin
              state_q     <= IDLE;
              hreadyout_q <= 1'b1;
              hresp_q     <= RESP_OKAY;
            end
          end else begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
            dp_active_q <= 1'b0;
            err_q       <= 1'b0;
          end
        end
      endcase
    end
  end

  mem_ahb_byte_en #(
    .DATA(DATA)
  ) u_byte_en (
    .size  (size_q),
    .addr  (addr_q[LB-1:0]),
    .strobe(byte_en)
  );

  assign word_idx  = addr_q[LB +: AW];
  assign wr_commit = dp_active_q && write_q && !err_q && hreadyout_q && !hreset;

  // Storage carries no reset unless clearing is requested, so it maps onto block RAM.
  always_ff @(posedge hclk) begin
    if (hreset && (INIT_ZERO != 0)) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_commit) begin
      for (int b = 0; b < NB; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata    = (dp_active_q && !write_q && !err_q) ? mem[word_idx] : '0;
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;

  assign unused_bits = ^{hburst, addr_q};

endmodule
